// File: rtl/instruction_fetch_memory.sv
// Writable instruction store with a ready/valid fetch port.
// After reset, the store fills itself with RESET_FILL. It then serves registered fetches with fault flags.
module instruction_fetch_memory #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned PC_WIDTH   = 32,
    parameter logic [31:0] RESET_FILL = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pc_valid,
    output logic                     pc_ready,
    input  logic [PC_WIDTH-1:0]      pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instruction_code,
    output logic [PC_WIDTH-1:0]      instr_pc,
    output logic [1:0]               fault,
    input  logic                     prog_en,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    input  logic [3:0]               prog_be,
    output logic                     init_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e              state;
    logic [AW-1:0]       fill_cnt;
    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic                misaligned;
    logic                out_of_range;
    logic [AW-1:0]       rd_idx;
    logic [PC_WIDTH-1:0] word_idx;

    assign word_idx     = pc >> 2;
    assign misaligned   = (pc[1:0] != 2'b00);
    assign out_of_range = (word_idx >= PC_WIDTH'(DEPTH));
    assign rd_idx       = pc[AW+1:2];

    assign pc_ready = (state == StReady) && (!instr_valid || instr_ready);
    assign accept   = pc_valid && pc_ready;

    // Storage has no reset; the INIT sweep rewrites every word instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == StInit) begin
                mem[fill_cnt] <= RESET_FILL;
            end else if (prog_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (prog_be[i]) begin
                        mem[prog_addr][8*i +: 8] <= prog_data[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= StInit;
            fill_cnt         <= '0;
            init_done        <= 1'b0;
            instr_valid      <= 1'b0;
            instruction_code <= '0;
            instr_pc         <= '0;
            fault            <= '0;
        end else begin
            case (state)
                StInit: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == AW'(DEPTH - 1)) begin
                        state     <= StReady;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state <= StReady;
                end
            endcase

            // Read-first: a same-cycle program write is seen by the next fetch.
            if (accept) begin
                instr_valid      <= 1'b1;
                instr_pc         <= pc;
                fault            <= {out_of_range, misaligned};
                instruction_code <= (misaligned || out_of_range) ? 32'h0 : mem[rd_idx];
            end else if (instr_valid && instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Scoreboard bench for instruction_fetch_memory (DEPTH=8).
// The driver queues expected responses, and a negedge monitor retires them.
module tb_instruction_fetch_memory;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pc_valid = 1'b0;
    logic          pc_ready;
    logic [PW-1:0] pc = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [31:0]   instruction_code;
    logic [PW-1:0] instr_pc;
    logic [1:0]    fault;
    logic          prog_en = 1'b0;
    logic [2:0]    prog_addr = '0;
    logic [31:0]   prog_data = '0;
    logic [3:0]    prog_be = '0;
    logic          init_done;

    int checks = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0]   code;
        logic [PW-1:0] pc;
        logic [1:0]    flt;
    } resp_t;

    resp_t exp_q[$];

    always #5 clk = ~clk;

    instruction_fetch_memory #(.DEPTH(DEPTH), .PC_WIDTH(PW), .RESET_FILL(32'h00000013)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_valid         (pc_valid),
        .pc_ready         (pc_ready),
        .pc               (pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instruction_code (instruction_code),
        .instr_pc         (instr_pc),
        .fault            (fault),
        .prog_en          (prog_en),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .prog_be          (prog_be),
        .init_done        (init_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: one retirement per negedge with valid && ready.
    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", instr_pc, 32'hFFFF_FFFF);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("resp_code", instruction_code, e.code);
                check("resp_pc", instr_pc, e.pc);
                check("resp_fault", {30'd0, fault}, {30'd0, e.flt});
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] code, input logic [1:0] f);
        int n;
        n = 0;
        pc_valid = 1'b1;
        pc       = a;
        forever begin
            @(negedge clk);
            if (pc_ready) break;
            n++;
            if (n > 200) begin
                check("fetch_timeout", a, 32'hFFFF_FFFF);
                pc_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back('{code: code, pc: a, flt: f});
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
    endtask

    task automatic prog(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
        prog_en   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        prog_be   = be;
        @(posedge clk);
        #1;
        prog_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Reset has just been released; expect exactly DEPTH cycles of fill.
    task automatic check_fill(input string name);
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            check({name, "_busy_ready"}, {31'd0, pc_ready}, 32'd0);
            check({name, "_busy_done"}, {31'd0, init_done}, 32'd0);
        end
        @(negedge clk);
        check({name, "_done"}, {31'd0, init_done}, 32'd1);
        check({name, "_ready"}, {31'd0, pc_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc_ready", {31'd0, pc_ready}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_code", instruction_code, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_fault", {30'd0, fault}, 32'd0);
        check("rst_done", {31'd0, init_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_fill("fill");

        // Whole memory holds the fill word
        for (int i = 0; i < int'(DEPTH); i++) fetch(32'(i * 4), 32'h00000013, 2'b00);
        drain("drain_fill");

        // Program and fetch
        prog(3'd0, 32'h002081B3, 4'hF);
        prog(3'd1, 32'h4020A1B3, 4'hF);
        fetch(32'h0, 32'h002081B3, 2'b00);
        fetch(32'h4, 32'h4020A1B3, 2'b00);
        prog(3'd0, 32'h00AB0000, 4'b0100);
        prog(3'd2, 32'hDEADBEEF, 4'b0000);
        fetch(32'h0, 32'h00AB81B3, 2'b00);
        fetch(32'h8, 32'h00000013, 2'b00);

        // Faults
        fetch(32'h02, 32'h0, 2'b01);
        fetch(32'h20, 32'h0, 2'b10);
        fetch(32'h22, 32'h0, 2'b11);
        drain("drain_prog");

        // Backpressure
        fetch(32'h0, 32'h00AB81B3, 2'b00);
        instr_ready = 1'b0;
        fork
            begin
                fetch(32'h4, 32'h4020A1B3, 2'b00);
                fetch(32'h8, 32'h00000013, 2'b00);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_pc_ready", {31'd0, pc_ready}, 32'd0);
                    check("stall_valid", {31'd0, instr_valid}, 32'd1);
                    check("stall_pc", instr_pc, 32'h0);
                    check("stall_code", instruction_code, 32'h00AB81B3);
                end
                @(posedge clk);
                #1;
                instr_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Same-cycle collision: the fetch sees the old word
        prog_en   = 1'b1;
        prog_addr = 3'd1;
        prog_data = 32'h11223344;
        prog_be   = 4'hF;
        pc_valid  = 1'b1;
        pc        = 32'h4;
        @(negedge clk);
        check("coll_pc_ready", {31'd0, pc_ready}, 32'd1);
        exp_q.push_back('{code: 32'h4020A1B3, pc: 32'h4, flt: 2'b00});
        @(posedge clk);
        #1;
        prog_en  = 1'b0;
        pc_valid = 1'b0;
        fetch(32'h4, 32'h11223344, 2'b00);
        drain("drain_coll");

        // Reset drops a held response and overwrites program writes
        instr_ready = 1'b0;
        fetch(32'h4, 32'h11223344, 2'b00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drop_valid", {31'd0, instr_valid}, 32'd0);
        exp_q.delete();
        instr_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Fill counter now at 3
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_fill("refill");
        fetch(32'h4, 32'h00000013, 2'b00);
        fetch(32'h0, 32'h00000013, 2'b00);
        drain("drain_end");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch_memory.md
# instruction_fetch_memory

Parametrised, writable instruction memory with a ready/valid fetch port, replacing the fixed hard-coded program store. On reset it fills every word with a configurable fill instruction (default NOP), then serves 32-bit little-endian instruction fetches with one-cycle registered latency and output backpressure. It flags misaligned and out-of-range PCs, and accepts byte-enabled program-load writes from a loader or testbench. It sits between the PC/fetch stage and the decoder.

## Interface
- DEPTH, 64: memory size in 32-bit words; power of 2, at least 2.
- PC_WIDTH, 32: width of the fetch address.
- RESET_FILL, 32'h00000013: word written to every location during init.
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_valid  input  1  fetch request valid.
- pc_ready  output  1  block can accept a fetch this cycle.
- pc  input  PC_WIDTH  byte address of the fetch.
- instr_valid  output  1  response valid.
- instr_ready  input  1  consumer accepts the response.
- instruction_code  output  32  fetched instruction; byte at pc is in [7:0].
- instr_pc  output  PC_WIDTH  PC of the current response.
- fault  output  2  bit0 = misaligned (pc[1:0]≠0), bit1 = out of range (pc>>2 ≥ DEPTH).
- prog_en  input  1  program-write strobe.
- prog_addr  input  $clog2(DEPTH)  word index to write.
- prog_data  input  32  write data, little-endian.
- prog_be  input  4  byte enables; bit i enables prog_data[8i+7:8i].
- init_done  output  1  high once the fill has completed.

## Operation
- Reset values: pc_ready=0, instr_valid=0, instruction_code=0, instr_pc=0, fault=0, init_done=0. The FSM goes to INIT and the fill counter goes to 0.
- **INIT state:**
  - Each cycle, write RESET_FILL to word[counter], then increment the counter.
  - On the edge where counter==DEPTH-1, go to READY and set init_done=1.
  - pc_ready=0 throughout; prog_en is ignored (the write is dropped).
- **READY state:**
  - init_done stays 1 until the next reset. There is no exit except reset.
- **Fetch handshake:**
  - A fetch is accepted when pc_valid && pc_ready.
  - pc_ready = READY && (!instr_valid || instr_ready), so a full output register plus an accept in the same cycle gives back-to-back throughput.
- **Response contents:**
  - On accept, the output register loads instruction_code = word[pc>>2], instr_pc = pc, the fault bits, and instr_valid=1.
  - If either fault bit is set, instruction_code = 32'h0, and no memory word is required to be read.
  - Index computation uses pc[$clog2(DEPTH)+1:2]; the range check uses the full pc.
- **Response retirement and stall:**
  - instr_valid clears when instr_valid && instr_ready && no new accept.
  - While instr_valid && !instr_ready, instruction_code, instr_pc and fault hold stable.
- **Program write (READY only):**
  - On prog_en, update the enabled bytes of word[prog_addr]. prog_be=0 writes nothing.
- **Simultaneous fetch and write to the same word:** the read is read-first; the fetch returns the old contents, and the new contents are visible from the next accepted fetch.
- **Reset mid-operation:**
  - Reset asserted at any time (including mid-INIT) restarts the fill at word 0 and drops any pending response (instr_valid=0).
  - Earlier program writes are overwritten by the fill.
- No other state. No combinational path from pc to instruction_code.

## Timing
- Fetch latency is 1 cycle: accept at edge N gives instr_valid=1 with data after edge N.
- Throughput is 1 fetch/cycle while instr_ready=1.
- Init takes exactly DEPTH cycles after reset deasserts. init_done and pc_ready (given no held response) rise after the DEPTH-th edge with reset low.
- A program write takes effect at the clock edge where prog_en=1. A fetch accepted on the following edge sees the new data.
- pc_ready depends combinationally on instr_ready. instr_valid, instruction_code, instr_pc and fault are all registered.

## Test plan
- **Reset fill:** DEPTH=8, reset for 1 cycle, then low.
  - Required: pc_ready=0 for 8 cycles, init_done=1 after the 8th edge.
  - Fetches at pc=0x0,0x4,…,0x1C then each return 0x00000013 with fault=0.
- **Program and fetch:** write 0x002081B3 to word 0 and 0x4020A1B3 to word 1 with prog_be=4'hF.
  - Fetch pc=0x0 → 0x002081B3. Fetch pc=0x4 → 0x4020A1B3.
- **Partial write:** prog_be=4'b0100, prog_data=0x00AB0000 to word 0 holding 0x002081B3 → fetch returns 0x00AB81B3.
- **Faults (DEPTH=8):**
  - pc=0x2 → fault=2'b01, code=0.
  - pc=0x20 → fault=2'b10, code=0.
  - pc=0x22 → fault=2'b11, code=0.
- **Backpressure:** issue back-to-back fetches 0x0,0x4,0x8 with instr_ready held low for 3 cycles after the first response.
  - Required: pc_ready=0 while stalled, response for 0x0 held stable.
  - Responses then arrive in order with none lost or duplicated.
- **Same-cycle collision and reset mid-init:**
  - Fetch pc=0x4 while writing word 1 in the same cycle → old data returned; the next fetch of pc=0x4 returns the new data.
  - Reset asserted at fill counter 3 → a fresh 8-cycle fill follows before init_done=1.
